// File: rtl/down_cnt_timer_pkg.sv
// Shared encodings for the down-counting timer: FSM states and MODE values.
package down_cnt_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/down_cnt_timer_tick_prescaler.sv
// Prescaler for the down-counting timer: one tick every PRE+1 cycles with run high.
module down_cnt_timer_tick_prescaler #(
  parameter int unsigned PRE_BITS = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                clear,
  input  logic                run,
  input  logic [PRE_BITS-1:0] PRE,
  output logic                tick
);

  logic [PRE_BITS-1:0] cnt_q;
  logic                at_limit;

  // >= rather than == so that lowering PRE mid-run cannot strand the counter above it
  assign at_limit = (cnt_q >= PRE);
  assign tick     = run && at_limit;

  always_ff @(posedge CLK) begin
    if (CLR || clear) begin
      cnt_q <= '0;
    end else if (run) begin
      if (at_limit) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + PRE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/down_cnt_timer.sv
// Programmable down-counting timer with prescaler, one-shot / auto-reload and pause.
module down_cnt_timer
  import down_cnt_timer_pkg::*;
#(
  parameter int unsigned Bits     = 8,
  parameter int unsigned PRE_BITS = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                EN,
  input  logic                LOAD,
  input  logic [Bits-1:0]     D,
  input  logic [PRE_BITS-1:0] PRE,
  input  logic                MODE,
  input  logic                START,
  input  logic                STOP,
  output logic [Bits-1:0]     Q,
  output logic                TC,
  output logic                BUSY,
  output logic                ZERO
);

  state_e          state_q;
  logic [Bits-1:0] q_q;
  logic [Bits-1:0] reload_q;
  logic            tc_q;
  logic            tick;
  logic            pre_run;
  logic            pre_clear;

  // STOP takes priority in RUN, so the prescaler must not advance on that cycle either
  assign pre_run   = (state_q == ST_RUN) && EN && !STOP;
  assign pre_clear = (state_q == ST_IDLE) && START && !STOP;

  down_cnt_timer_tick_prescaler #(
    .PRE_BITS(PRE_BITS)
  ) u_prescaler (
    .CLK  (CLK),
    .CLR  (CLR),
    .clear(pre_clear),
    .run  (pre_run),
    .PRE  (PRE),
    .tick (tick)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (LOAD) begin
        reload_q <= D;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (START && !STOP) begin
            q_q     <= LOAD ? D : reload_q;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (STOP) begin
            state_q <= ST_PAUSE;
          end else if (tick) begin
            if (q_q != '0) begin
              q_q <= q_q - Bits'(1);
            end else begin
              tc_q <= 1'b1;
              if (MODE == MODE_RELOAD) begin
                q_q <= reload_q;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (START && !STOP) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign TC   = tc_q;
  assign BUSY = (state_q == ST_RUN);
  assign ZERO = (q_q == '0);

endmodule
